// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller: FSM encodings and scoreboard field widths.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int SB_VALID_W     = 1;
  localparam int SB_LOAD_W      = 1;
  localparam int FLUSH_CNT_W    = 3;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_FLUSH = 2'd1,
    HZ_DRAIN = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute side signals of the hazard controller; master = pipeline, slave = controller.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
);
  logic                  i_id_valid;
  logic [REG_ADDR_W-1:0] i_id_rs1_addr;
  logic [REG_ADDR_W-1:0] i_id_rs2_addr;
  logic                  i_id_uses_rs1;
  logic                  i_id_uses_rs2;
  logic [REG_ADDR_W-1:0] i_id_rd_addr;
  logic                  i_id_wr_rd;
  logic                  i_id_is_load;
  logic                  i_ex_redirect;
  logic                  i_mem_busy;
  logic                  i_trap;
  logic                  o_stall_if;
  logic                  o_stall_id;
  logic                  o_flush_if;
  logic                  o_flush_id;
  logic                  o_ex_bubble;
  logic                  o_trap_ack;
  logic                  o_busy;

  modport master (
    output i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
           i_id_rd_addr, i_id_wr_rd, i_id_is_load, i_ex_redirect, i_mem_busy, i_trap,
    input  o_stall_if, o_stall_id, o_flush_if, o_flush_id, o_ex_bubble, o_trap_ack, o_busy
  );

  modport slave (
    input  i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
           i_id_rd_addr, i_id_wr_rd, i_id_is_load, i_ex_redirect, i_mem_busy, i_trap,
    output o_stall_if, o_stall_id, o_flush_if, o_flush_id, o_ex_bubble, o_trap_ack, o_busy
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// EX/MEM/WB destination-register scoreboard with RAW match against decode sources.
// HAZARD_CTRL_FORWARDING_EN: only a load in EX can raise a hazard.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_shift,
  input  logic                  i_issue,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_wr_rd,
  input  logic                  i_is_load,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic                  i_uses_rs1,
  input  logic                  i_uses_rs2,
  output logic                  o_hazard,
  output logic                  o_empty
);

  logic                  vld_p0, vld_p1, vld_p2;
  logic [REG_ADDR_W-1:0] rd_p0;
  logic                  match_ex;

  // p0 = EX, p1 = MEM, p2 = WB; valid bits are control and reset, fields are not
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (i_shift) begin
      vld_p2 <= vld_p1;
      vld_p1 <= vld_p0;
      vld_p0 <= i_issue & i_wr_rd & (i_rd != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_shift) rd_p0 <= i_rd;
  end

  assign match_ex = vld_p0 & ((i_uses_rs1 & (i_rs1 == rd_p0)) |
                              (i_uses_rs2 & (i_rs2 == rd_p0)));

`ifdef HAZARD_CTRL_FORWARDING_EN
  logic ld_p0;

  always_ff @(posedge i_clk) begin
    if (i_shift) ld_p0 <= i_is_load;
  end

  assign o_hazard = match_ex & ld_p0;
`else
  logic [REG_ADDR_W-1:0] rd_p1;
  logic                  match_mem;
  logic                  unused_is_load;

  always_ff @(posedge i_clk) begin
    if (i_shift) rd_p1 <= rd_p0;
  end

  assign match_mem = vld_p1 & ((i_uses_rs1 & (i_rs1 == rd_p1)) |
                               (i_uses_rs2 & (i_rs2 == rd_p1)));
  assign unused_is_load = i_is_load;
  assign o_hazard = match_ex | match_mem;
`endif

  assign o_empty = ~(vld_p0 | vld_p1 | vld_p2);

endmodule

// File: rtl/hazard_ctrl.sv
// RV32I pipeline sequencer: RAW interlock, redirect flush and trap drain FSM.
// Define HAZARD_CTRL_FORWARDING_EN to interlock only on load-use pairs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  hz_state_e              state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic stall_if, stall_id, flush_if, flush_id, bubble, trap_ack;
  logic hazard, sb_empty, issue;

  assign issue = hz.i_id_valid & ~stall_id & ~flush_id;

  hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_shift    (~hz.i_mem_busy),
    .i_issue    (issue),
    .i_rd       (hz.i_id_rd_addr),
    .i_wr_rd    (hz.i_id_wr_rd),
    .i_is_load  (hz.i_id_is_load),
    .i_rs1      (hz.i_id_rs1_addr),
    .i_rs2      (hz.i_id_rs2_addr),
    .i_uses_rs1 (hz.i_id_uses_rs1),
    .i_uses_rs2 (hz.i_id_uses_rs2),
    .o_hazard   (hazard),
    .o_empty    (sb_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority: trap > redirect > mem_busy > data hazard
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_if = 1'b0;
    flush_id = 1'b0;
    bubble   = 1'b0;
    trap_ack = 1'b0;
    case (state_q)
      HZ_RUN, HZ_FLUSH: begin
        if (hz.i_trap) begin
          state_d  = HZ_DRAIN;
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_id = 1'b1;
          bubble   = 1'b1;
        end else if (hz.i_ex_redirect) begin
          state_d  = (FLUSH_CYCLES > 1) ? HZ_FLUSH : HZ_RUN;
          cnt_d    = FLUSH_LOAD;
          flush_if = 1'b1;
          flush_id = 1'b1;
          bubble   = 1'b1;
        end else if (state_q == HZ_FLUSH) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
          bubble   = 1'b1;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q <= 1) state_d = HZ_RUN;
        end else if (hz.i_mem_busy) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
        end else if (hazard & hz.i_id_valid) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          bubble   = 1'b1;
        end
      end
      HZ_DRAIN: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_id = 1'b1;
        bubble   = 1'b1;
        if (sb_empty & ~hz.i_mem_busy) begin
          trap_ack = 1'b1;
          state_d  = HZ_RUN;
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  // Outputs are forced low while reset is held so a mid-drain reset never acks
  assign hz.o_stall_if  = stall_if & ~i_rst;
  assign hz.o_stall_id  = stall_id & ~i_rst;
  assign hz.o_flush_if  = flush_if & ~i_rst;
  assign hz.o_flush_id  = flush_id & ~i_rst;
  assign hz.o_ex_bubble = bubble   & ~i_rst;
  assign hz.o_trap_ack  = trap_ack & ~i_rst;
  assign hz.o_busy      = (state_q != HZ_RUN) & ~i_rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES=2); expectations follow HAZARD_CTRL_FORWARDING_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {stall_if, stall_id, flush_if, flush_id, ex_bubble, trap_ack, busy}
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_HAZ   = 7'b1100100;
  localparam logic [6:0] O_MEMB  = 7'b1100000;
  localparam logic [6:0] O_REDIR = 7'b0011100;
  localparam logic [6:0] O_FLUSH = 7'b0011101;
  localparam logic [6:0] O_TRAP  = 7'b1101100;
  localparam logic [6:0] O_DRAIN = 7'b1101101;
  localparam logic [6:0] O_ACK   = 7'b1101111;
  localparam logic [6:0] O_NOFWD = FWD ? O_IDLE : O_HAZ;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

  hazard_ctrl #(.FLUSH_CYCLES(2), .REG_ADDR_W(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .hz    (hz.slave)
  );

  task automatic set_id(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
    hz.i_id_valid    = v;
    hz.i_id_rd_addr  = rd;
    hz.i_id_wr_rd    = wr;
    hz.i_id_is_load  = ld;
    hz.i_id_rs1_addr = rs1;
    hz.i_id_uses_rs1 = u1;
    hz.i_id_rs2_addr = rs2;
    hz.i_id_uses_rs2 = u2;
  endtask

  task automatic cyc(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    #1;
    obs = {hz.o_stall_if, hz.o_stall_id, hz.o_flush_if, hz.o_flush_id,
           hz.o_ex_bubble, hz.o_trap_ack, hz.o_busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_drain(input string tag);
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(tag, O_IDLE);
  endtask

  initial begin
    rst = 1'b1;
    hz.i_ex_redirect = 1'b0;
    hz.i_mem_busy    = 1'b0;
    hz.i_trap        = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc("reset0", O_IDLE);
    hz.i_trap = 1'b1;
    cyc("reset_trap", O_IDLE);
    hz.i_trap = 1'b0;
    rst = 1'b0;
    cyc("post_reset", O_IDLE);

    // ADD x5 then reader of x5: two stalls without forwarding
    set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
    cyc("add_issue", O_IDLE);
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    cyc("raw_ex", O_NOFWD);
    cyc("raw_mem", O_NOFWD);
    cyc("raw_issue", O_IDLE);
    idle_drain("drain_a");

    // LW x7 then reader of x7: exactly one stall with forwarding
    set_id(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc("lw_issue", O_IDLE);
    set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
    cyc("lu_ex", O_HAZ);
    cyc("lu_mem", O_NOFWD);
    cyc("lu_issue", O_IDLE);
    idle_drain("drain_b");

    // x0 writer/reader never stall; rs2 match gated by uses_rs2
    set_id(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc("x0_write", O_IDLE);
    set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
    cyc("x0_read", O_IDLE);
    set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc("x9_write", O_IDLE);
    set_id(1'b1, 5'd10, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0);
    cyc("rs2_unused", O_IDLE);
    set_id(1'b1, 5'd10, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    cyc("rs2_mem", O_NOFWD);
    idle_drain("drain_c");

    // mem_busy beats the hazard: stall without bubble, scoreboard holds
    set_id(1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc("x11_write", O_IDLE);
    set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 5'd0, 1'b0);
    hz.i_mem_busy = 1'b1;
    cyc("membusy", O_MEMB);
    hz.i_mem_busy = 1'b0;
    cyc("membusy_hold", O_NOFWD);
    idle_drain("drain_d");

    // redirect wins over hazard, then double redirect extends the flush
    set_id(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc("x12_write", O_IDLE);
    set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0);
    hz.i_ex_redirect = 1'b1;
    cyc("redir_haz", O_REDIR);
    hz.i_ex_redirect = 1'b0;
    cyc("flush1", O_FLUSH);
    cyc("flush_done", O_IDLE);
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    hz.i_ex_redirect = 1'b1;
    cyc("redir2", O_REDIR);
    cyc("redir_in_flush", O_FLUSH);
    hz.i_ex_redirect = 1'b0;
    cyc("flush_ext", O_FLUSH);
    cyc("flush_ext_done", O_IDLE);

    // trap with three live entries and two mem_busy cycles: ack 5 cycles later
    set_id(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc("fill1", O_IDLE);
    set_id(1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc("fill2", O_IDLE);
    set_id(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc("fill3", O_IDLE);
    set_id(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    hz.i_trap = 1'b1;
    cyc("trap", O_TRAP);
    hz.i_trap = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    hz.i_mem_busy = 1'b1;
    cyc("drain_busy1", O_DRAIN);
    cyc("drain_busy2", O_DRAIN);
    hz.i_mem_busy = 1'b0;
    hz.i_ex_redirect = 1'b1;
    cyc("drain_redir_ign", O_DRAIN);
    hz.i_ex_redirect = 1'b0;
    cyc("drain4", O_DRAIN);
    cyc("trap_ack", O_ACK);
    cyc("after_ack", O_IDLE);

    // reset mid-drain: outputs drop, scoreboard cleared, no ack
    set_id(1'b1, 5'd13, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc("x13_write", O_IDLE);
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    hz.i_trap = 1'b1;
    cyc("trap2", O_TRAP);
    hz.i_trap = 1'b0;
    hz.i_mem_busy = 1'b1;
    cyc("drain_pre_rst", O_DRAIN);
    rst = 1'b1;
    cyc("rst_in_drain", O_IDLE);
    rst = 1'b0;
    hz.i_mem_busy = 1'b0;
    set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd13, 1'b1, 5'd0, 1'b0);
    cyc("post_rst_sb_clear", O_IDLE);
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc("post_rst_noack1", O_IDLE);
    cyc("post_rst_noack2", O_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the RV32I in-order core; sits beside the fetch/decode/execute stages.
- Tracks destination registers of in-flight instructions in a 3-entry scoreboard (EX, MEM, WB).
- Detects RAW hazards against the source addresses currently presented by the decode stage.
- Generates the stall, flush and bubble controls for fetch/decode, and sequences branch-redirect flushes and trap drains.

Parameters:
- FLUSH_CYCLES, 2, cycles the flush controls stay asserted after a redirect (1..7).
- REG_ADDR_W, 5, register address width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_id_valid  in  1  decode stage holds a valid instruction
- i_id_rs1_addr  in  REG_ADDR_W  unregistered rs1 address from decode
- i_id_rs2_addr  in  REG_ADDR_W  unregistered rs2 address from decode
- i_id_uses_rs1  in  1  instruction reads rs1
- i_id_uses_rs2  in  1  instruction reads rs2
- i_id_rd_addr  in  REG_ADDR_W  destination register of the decode instruction
- i_id_wr_rd  in  1  instruction writes rd
- i_id_is_load  in  1  instruction is a LOAD
- i_ex_redirect  in  1  taken branch / JAL / JALR resolved in EX (1-cycle pulse)
- i_mem_busy  in  1  MEM stage waiting on data memory
- i_trap  in  1  exception/ECALL/EBREAK/MRET request (pulse)
- o_stall_if  out  1  hold fetch
- o_stall_id  out  1  hold decode
- o_flush_if  out  1  kill fetch output
- o_flush_id  out  1  kill decode output
- o_ex_bubble  out  1  clock-enable of EX forced low this cycle
- o_trap_ack  out  1  pipeline drained; trap may redirect PC (1-cycle pulse)
- o_busy  out  1  FSM not in RUN

Behaviour:
- Reset (sync, i_rst=1): FSM=RUN, flush counter=0, all scoreboard entries invalid, every output 0.

Scoreboard:
- Entry = {valid, rd, is_load}.
- On any cycle with i_mem_busy=0, the scoreboard shifts WB<=MEM, MEM<=EX.
- EX is loaded with the decode instruction when it issues: i_id_valid & !stall & !flush. valid = i_id_wr_rd & (rd!=0).
- Otherwise EX is loaded with an invalid entry (bubble).
- With i_mem_busy=1, all entries hold.

Hazard match:
- match_X(rs) = entry_X.valid & uses & (rs==entry_X.rd). rd=0 never matches.
- WB is never a hazard; the register file is write-before-read.
- hazard = match in EX or MEM, for rs1 or rs2.
- When hazard & i_id_valid:
  - o_stall_if=1, o_stall_id=1, o_ex_bubble=1.
  - Combinational; no latency; persists until the producer retires past MEM.

FSM (RUN, FLUSH, DRAIN):
- RUN:
  - i_trap → DRAIN.
  - Else i_ex_redirect → FLUSH; counter loads FLUSH_CYCLES-1; o_flush_if=o_flush_id=o_ex_bubble=1 in the redirect cycle itself.
- FLUSH:
  - o_flush_if=o_flush_id=o_ex_bubble=1.
  - Counter decrements each cycle; at 0 → RUN.
  - A redirect in FLUSH reloads the counter.
  - i_trap in FLUSH → DRAIN.
- DRAIN:
  - o_stall_if=o_stall_id=o_flush_id=o_ex_bubble=1.
  - Scoreboard keeps shifting bubbles.
  - When EX, MEM and WB are all invalid and i_mem_busy=0: o_trap_ack=1 for one cycle → RUN.
  - i_ex_redirect is ignored in DRAIN.
- o_busy = (state!=RUN).

Priority per cycle: reset > trap > redirect > mem_busy > data hazard.
- i_mem_busy=1 in RUN: o_stall_if=o_stall_id=1, no bubble, no scoreboard shift.
- Redirect and hazard in the same cycle: flush wins; the hazard stall is suppressed.
- Reset mid-FLUSH/DRAIN: returns to RUN with no o_trap_ack.

Optional Feature:
- HAZARD_CTRL_FORWARDING_EN defined:
  - Forwarding paths exist, so only load-use stalls.
  - hazard = match in EX with entry_EX.is_load=1. MEM matches are ignored.
  - Exactly one bubble per load-use pair.
- Undefined: full interlock as described in Behaviour (EX or MEM matches stall).

Decomposition:
- Shared package/header (RV32I_Headers.vh):
  - FSM state encodings: HZ_RUN, HZ_FLUSH, HZ_DRAIN.
  - Scoreboard entry field widths.
  - REG_ADDR_W default.
- One natural sub-module, hazard_scoreboard: 3-entry shift register plus match logic. The parent keeps the FSM and output muxing.

Test Plan:
- ADD x5 issued; next instruction reads rs1=x5, no forwarding → 2 stall cycles (x5 in EX, then MEM), 2 EX bubbles. With FORWARDING_EN → 0 stalls.
- LW x7 then ADD reads x7, FORWARDING_EN → exactly 1 stall cycle, 1 bubble, then issue.
- Instruction writing x0 followed by a reader of x0 → no stall.
- i_ex_redirect pulse, FLUSH_CYCLES=2 → o_flush_if/o_flush_id high 2 cycles, o_busy high 1 cycle, back to RUN. Second redirect during FLUSH → flush extends 2 more cycles.
- i_trap with 3 valid entries and i_mem_busy high 2 cycles → stall/flush held; o_trap_ack single pulse at 3+2=5 cycles after the trap cycle, then RUN.
- i_rst asserted during DRAIN → next cycle all outputs 0, state RUN, o_trap_ack never pulses.
